// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned MIN_PRESCALE = 4;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with majority-of-3 sampling around the bit centre.
// The prescale is captured on start detection so mid-frame changes are ignored.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESC_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               rx_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic               active_i,
  input  logic [PRESC_W-1:0] prescale_i,
  output logic               dec_stb_o,
  output logic               dec_bit_o,
  output logic               bit_end_o
);

  logic [PRESC_W-1:0] p_q, p_d;
  logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
  logic               s0_q, s0_d, s1_q, s1_d;
  logic [PRESC_W-1:0] half;
  logic               last_edge;

  assign half      = p_q >> 1;
  assign last_edge = (edge_cnt_q == p_q - 1'b1);

  // Edge counting, prescale capture and the two early centre samples.
  always_comb begin
    p_d        = p_q;
    edge_cnt_d = edge_cnt_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    if (start_i) begin
      // The detection cycle is edge 0, so the next cycle is edge 1.
      p_d        = (prescale_i < PRESC_W'(MIN_PRESCALE)) ? PRESC_W'(MIN_PRESCALE) : prescale_i;
      edge_cnt_d = PRESC_W'(1);
    end else if (clear_i || !active_i) begin
      edge_cnt_d = '0;
    end else begin
      edge_cnt_d = last_edge ? '0 : edge_cnt_q + 1'b1;
    end
    if (active_i && edge_cnt_q == half - 1'b1) s0_d = rx_i;
    if (active_i && edge_cnt_q == half)        s1_d = rx_i;
  end

  // Sampler state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      p_q        <= PRESC_W'(MIN_PRESCALE);
      edge_cnt_q <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
    end else begin
      p_q        <= p_d;
      edge_cnt_q <= edge_cnt_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
    end
  end

  // Decision at edge P/2+1 uses the live sample as the third vote.
  assign dec_stb_o = active_i && (edge_cnt_q == half + 1'b1);
  assign dec_bit_o = (s0_q & s1_q) | (s0_q & rx_i) | (s1_q & rx_i);
  assign bit_end_o = active_i && last_edge;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start / DATA_WIDTH data bits LSB first / optional parity / stop.
// Optional build macro UART_RX_SYNC_EN adds a 2-flop input synchronizer on RX_IN.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic rx;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;
  // Two-flop synchronizer, idle-high after reset.
  always_ff @(posedge clk) begin
    if (!rstn) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], RX_IN};
  end
  assign rx = sync_q[1];
`else
  assign rx = RX_IN;
`endif

  rx_state_t             state_q, state_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic                  par_bad_q, par_bad_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d, stp_err_q, stp_err_d;

  logic start_stb, clear, active, dec_stb, dec_bit, bit_end, last_bit;

  assign start_stb = (state_q == IDLE) && !rx;
  assign active    = (state_q != IDLE);
  assign last_bit  = (bit_cnt_q == BitCntW'(DATA_WIDTH - 1));
  // Leaving to IDLE from START (glitch) or STOP (decision) resets the edge counter.
  assign clear     = dec_stb && (((state_q == START) && dec_bit) || (state_q == STOP));

  uart_rx_sampler #(
    .PRESC_W (PRESC_W)
  ) u_sampler (
    .clk_i      (clk),
    .rst_ni     (rstn),
    .rx_i       (rx),
    .start_i    (start_stb),
    .clear_i    (clear),
    .active_i   (active),
    .prescale_i (prescale),
    .dec_stb_o  (dec_stb),
    .dec_bit_o  (dec_bit),
    .bit_end_o  (bit_end)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (!rx) state_d = START;
      START: begin
        if (dec_stb && dec_bit) state_d = IDLE;
        else if (bit_end)       state_d = DATA;
      end
      DATA:   if (bit_end && last_bit) state_d = par_en_q ? PARITY : STOP;
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (dec_stb) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and frame-result next values.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    p_data_d     = p_data_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_bad_d    = par_bad_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx) begin
          par_en_d  = par_en;
          par_typ_d = par_typ;
          par_bad_d = 1'b0;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (dec_stb) shreg_d = {dec_bit, shreg_q[DATA_WIDTH-1:1]};
        if (bit_end) bit_cnt_d = bit_cnt_q + 1'b1;
      end
      PARITY: begin
        if (dec_stb) par_bad_d = dec_bit != ((^shreg_q) ^ (par_typ_q == PAR_ODD));
      end
      STOP: begin
        if (dec_stb) begin
          stp_err_d = !dec_bit;
          par_err_d = par_bad_q;
          if (dec_bit && !par_bad_q) begin
            data_valid_d = 1'b1;
            p_data_d     = shreg_q;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      p_data_q     <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      p_data_q     <= p_data_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_bad_q    <= par_bad_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a scoreboard of expected frame results.
module tb_uart_rx;
  import uart_rx_pkg::*;

`ifdef UART_RX_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       RX_IN;
  logic [5:0] prescale;
  logic       par_en, par_typ;
  logic [7:0] P_DATA;
  logic       data_valid, par_err, stp_err;

  uart_rx #(
    .DATA_WIDTH (8),
    .PRESC_W    (6)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .RX_IN      (RX_IN),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // flags = {par_err, stp_err, data_valid}
  typedef struct {
    logic [2:0] flags;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;
  int         npass = 0, nfail = 0, ntotal = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    ntotal++;
    assert (got === want) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rstn === 1'b1 && (data_valid || par_err || stp_err)) begin
      if (sb.size() == 0) begin
        check("spurious_pulse", {29'b0, par_err, stp_err, data_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("flags", {29'b0, par_err, stp_err, data_valid}, {29'b0, e.flags});
        check("p_data", {24'b0, P_DATA}, {24'b0, e.data});
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drive_bit(input logic b, input int n);
    RX_IN = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic send(input logic [7:0] d, input int p, input bit pe, input bit pt,
                      input bit flip, input bit stopv, input int newp);
    exp_t e;
    logic pbit;
    int   s;
    prescale = 6'(p);
    par_en   = pe;
    par_typ  = pt;
    pbit     = (^d) ^ pt ^ flip;
    s        = pe ? 10 : 9;
    e.flags  = {pe & flip, ~stopv, ~(pe & flip) & stopv};
    e.data   = e.flags[0] ? d : last_good;
    e.cyc    = cyc + s * p + p / 2 + 2 + Lat;
    if (e.flags[0]) last_good = d;
    sb.push_back(e);
    drive_bit(1'b0, p);
    prescale = 6'(newp);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pe) drive_bit(pbit, p);
    drive_bit(stopv, p);
    RX_IN = 1'b1;
  endtask

  initial begin
    exp_t e;
    int   t0;
    rstn = 1'b0; RX_IN = 1'b1; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_p_data", {24'b0, P_DATA}, 32'h0);
    check("rst_valid", {31'b0, data_valid}, 32'h0);
    check("rst_par_err", {31'b0, par_err}, 32'h0);
    check("rst_stp_err", {31'b0, stp_err}, 32'h0);
    @(posedge clk); #1;
    idle(5);

    // Even parity, good frame.
    send(8'hA5, 8, 1'b1, PAR_EVEN, 1'b0, 1'b1, 8);
    idle(20);
    // Odd parity with a wrong parity bit.
    send(8'h3C, 16, 1'b1, PAR_ODD, 1'b1, 1'b1, 16);
    idle(20);
    // Stop bit low.
    send(8'h55, 8, 1'b0, PAR_EVEN, 1'b0, 1'b0, 8);
    idle(20);
    // Two-cycle glitch must be rejected, then a real frame.
    drive_bit(1'b0, 2);
    idle(20);
    send(8'h0F, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 8);
    idle(20);
    // Back-to-back at P=32 with prescale disturbed mid-frame.
    send(8'h81, 32, 1'b0, PAR_EVEN, 1'b0, 1'b1, 8);
    send(8'h7E, 32, 1'b0, PAR_EVEN, 1'b0, 1'b1, 8);
    idle(20);

    // Reset in the middle of DATA abandons the frame.
    prescale = 6'd8; par_en = 1'b0;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 4);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    last_good = 8'h00;
    @(negedge clk);
    check("midrst_p_data", {24'b0, P_DATA}, 32'h0);
    check("midrst_valid", {31'b0, data_valid}, 32'h0);
    check("midrst_state", {29'b0, dut.state_q}, {29'b0, IDLE});
    @(posedge clk); #1;
    idle(20);
    send(8'hC3, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 8);
    idle(20);

    // Line stuck low: periodic stop errors, then recovery.
    prescale = 6'd8; par_en = 1'b0;
    t0 = cyc;
    e.flags = 3'b010; e.data = last_good; e.cyc = t0 + 78 + Lat;
    sb.push_back(e);
    e.cyc = t0 + 156 + Lat;
    sb.push_back(e);
    drive_bit(1'b0, 157);
    idle(30);
    send(8'h96, 8, 1'b1, PAR_ODD, 1'b0, 1'b1, 8);
    idle(40);

    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
